// File: rtl/bcd_score_pkg.sv
// bcd_score_pkg: shared FSM states, seven-segment table and single-digit BCD adder
package bcd_score_pkg;
  typedef enum logic {IDLE, ADD} state_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'd0, c};
    return (s > 5'd9) ? {1'b1, 4'(s - 5'd10)} : s;
  endfunction
endpackage

// File: rtl/bcd_seg_decoder.sv
// bcd_seg_decoder: one BCD digit to an active-low {g,f,e,d,c,b,a} pattern, with forced blank
module bcd_seg_decoder
  import bcd_score_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb seg = (blank || digit > 4'd9) ? SEG_BLANK : SEG_TABLE[digit];
endmodule

// File: rtl/bcd_score_engine.sv
// bcd_score_engine: BCD score with digit-serial saturating add, best score and 7-seg outputs.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module bcd_score_engine
  import bcd_score_pkg::*;
#(
  parameter int DIGITS     = 3,
  parameter int AMT_DIGITS = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    add_valid,
  output logic                    add_ready,
  input  logic [4*AMT_DIGITS-1:0] add_bcd,
  output logic                    add_done,
  output logic [4*DIGITS-1:0]     score_bcd,
  output logic [4*DIGITS-1:0]     best_bcd,
  output logic                    saturated,
  output logic [7*DIGITS-1:0]     seg_out
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};
  state_t state, state_nx;
  logic [4*DIGITS-1:0] operand, work, work_nx, amt_ext;
  logic [IW-1:0] idx;
  logic [4:0] dsum;
  logic [DIGITS-1:0] blank;
  logic carry, carry_nx, last, accept;
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = clear ? IDLE : (state == IDLE && add_valid) ? ADD : last ? IDLE : state;
  always_comb add_ready = state == IDLE;
  assign last = state == ADD && idx == LAST;
  assign accept = add_valid && add_ready && !clear;
  always_comb begin
    amt_ext = '0;
    for (int j = 0; j < AMT_DIGITS; j++)
      amt_ext[4*j +: 4] = add_bcd[4*j +: 4] > 4'd9 ? 4'd9 : add_bcd[4*j +: 4];
  end
  // only the digit at idx changes this cycle; work holds the partially added score
  always_comb begin
    work_nx = work;
    dsum = '0;
    for (int k = 0; k < DIGITS; k++)
      if (IW'(k) == idx) begin
        dsum = bcd_digit_add(work[4*k +: 4], operand[4*k +: 4], carry);
        work_nx[4*k +: 4] = dsum[3:0];
      end
    carry_nx = dsum[4];
  end
  always_ff @(posedge clock)
    if (reset) begin
      operand <= '0;
      work <= '0;
      idx <= '0;
      carry <= 1'b0;
      score_bcd <= '0;
      best_bcd <= '0;
      saturated <= 1'b0;
      add_done <= 1'b0;
    end else begin
      add_done <= !clear && last;
      if (add_done && score_bcd > best_bcd) best_bcd <= score_bcd;
      if (clear) begin
        score_bcd <= '0;
        saturated <= 1'b0;
      end else if (accept) begin
        operand <= amt_ext;
        work <= score_bcd;
        idx <= '0;
        carry <= 1'b0;
      end else if (state == ADD) begin
        work <= work_nx;
        carry <= carry_nx;
        idx <= idx + IW'(1);
        if (last) begin
          score_bcd <= (carry_nx || saturated) ? ALL_NINES : work_nx;
          saturated <= saturated | carry_nx;
        end
      end
    end
  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
`ifdef LEADING_ZERO_BLANK_EN
    assign blank[g] = (g > 0) && (score_bcd[4*DIGITS-1:4*g] == '0);
`else
    assign blank[g] = 1'b0;
`endif
    bcd_seg_decoder u_dec (
      .digit(score_bcd[4*g +: 4]),
      .blank(blank[g]),
      .seg  (seg_out[7*g +: 7])
    );
  end
endmodule

// File: tb/tb_bcd_score_engine.sv
// tb_bcd_score_engine: directed and randomized checks against a decimal-integer reference model
module tb_bcd_score_engine;
  localparam int D = 3;
  localparam int AD = 2;
  localparam int MAXV = 999;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  localparam logic [6:0] SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  logic clock = 1'b0;
  logic reset, clear, add_valid, add_ready, add_done, saturated;
  logic [4*AD-1:0] add_bcd;
  logic [4*D-1:0] score_bcd, best_bcd;
  logic [7*D-1:0] seg_out;
  int errors = 0;
  int checks = 0;
  int m_score, m_best, m_pend, m_busy;
  bit m_sat, m_done, m_ovf;

  always #5 clock = ~clock;

  bcd_score_engine #(.DIGITS(D), .AMT_DIGITS(AD)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .add_valid(add_valid), .add_ready(add_ready), .add_bcd(add_bcd),
    .add_done(add_done), .score_bcd(score_bcd), .best_bcd(best_bcd),
    .saturated(saturated), .seg_out(seg_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [7*D-1:0] exp_seg(input int v);
    logic [7*D-1:0] r;
    for (int i = 0; i < D; i++) begin
      r[7*i +: 7] = (LZ && i > 0 && v == 0) ? 7'b1111111 : SEG[v % 10];
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int amt_val(input logic [7:0] a);
    int s, p, n;
    s = 0;
    p = 1;
    for (int j = 0; j < AD; j++) begin
      n = int'(a[4*j +: 4]);
      s += (n > 9 ? 9 : n) * p;
      p *= 10;
    end
    return s;
  endfunction

  task automatic cyc(input bit r, input bit c, input bit v, input logic [7:0] a);
    reset = r;
    clear = c;
    add_valid = v;
    add_bcd = a;
    @(posedge clock);
    if (r) begin
      m_score = 0; m_best = 0; m_busy = 0; m_sat = 0; m_done = 0;
    end else begin
      if (m_done && m_score > m_best) m_best = m_score;
      if (c) begin
        m_score = 0; m_sat = 0; m_busy = 0; m_done = 0;
      end else if (m_busy > 0) begin
        m_busy--;
        m_done = m_busy == 0;
        if (m_done) begin
          m_score = m_pend;
          m_sat = m_sat | m_ovf;
        end
      end else begin
        m_done = 0;
        if (v) begin
          m_ovf = m_score + amt_val(a) > MAXV;
          m_pend = m_ovf ? MAXV : m_score + amt_val(a);
          m_busy = D;
        end
      end
    end
    @(negedge clock);
    check("score", score_bcd, to_bcd(m_score));
    check("best", best_bcd, to_bcd(m_best));
    check("saturated", saturated, m_sat);
    check("add_done", add_done, m_done);
    check("add_ready", add_ready, m_busy == 0);
    check("seg_out", seg_out, exp_seg(m_score));
  endtask

  task automatic add(input logic [7:0] a);
    cyc(0, 0, 1, a);
    repeat (D) cyc(0, 0, 0, '0);
  endtask

  initial begin
    repeat (2) cyc(1, 0, 0, '0);
    add(8'h07);
    check("score_007", score_bcd, 12'h007);
    check("seg0_7", seg_out[6:0], 7'b1111000);
    cyc(1, 0, 0, '0);
    add(8'h95);
    add(8'h07);
    check("score_102", score_bcd, 12'h102);
    cyc(0, 0, 0, '0);
    check("best_102", best_bcd, 12'h102);
    cyc(1, 0, 0, '0);
    repeat (10) add(8'h99);
    add(8'h05);
    check("score_995", score_bcd, 12'h995);
    add(8'h10);
    check("score_sat", score_bcd, 12'h999);
    check("sat_flag", saturated, 1'b1);
    add(8'h01);
    check("score_still_sat", score_bcd, 12'h999);
    cyc(0, 1, 1, 8'h05);
    add(8'h99);
    add(8'h99);
    add(8'h02);
    cyc(0, 0, 0, '0);
    check("score_200", score_bcd, 12'h200);
    cyc(0, 0, 1, 8'h05);
    cyc(0, 1, 0, '0);
    check("clear_score", score_bcd, 12'h000);
    check("clear_best", best_bcd, 12'h999);
    check("clear_ready", add_ready, 1'b1);
    repeat (D + 1) cyc(0, 0, 0, '0);
`ifdef LEADING_ZERO_BLANK_EN
    check("seg_lz_blank", seg_out[7*D-1:7], {2{7'b1111111}});
`else
    check("seg_zeros", seg_out[7*D-1:7], {2{7'b1000000}});
`endif
    add(8'h0F);
    check("score_009", score_bcd, 12'h009);
    repeat (4 * (D + 1)) cyc(0, 0, 1, 8'h01);
    repeat (D + 1) cyc(0, 0, 0, '0);
    cyc(0, 0, 1, 8'h11);
    cyc(0, 0, 0, '0);
    cyc(1, 0, 0, '0);
    check("rst_best", best_bcd, 12'h000);
    check("rst_ready", add_ready, 1'b1);
    repeat (800)
      cyc($urandom_range(0, 149) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 2) != 0, 8'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bcd_score_engine.md
Name: bcd_score_engine

Overview:
- Parametrised successor to the game's fixed 3-digit binary score, binary-to-BCD split and seven-segment path.
- Holds the running score directly in BCD, with N digits. Accepts add events through a ready/valid handshake and adds them digit-serially.
- Saturates at all nines, tracks a best (high) score, and drives one seven-segment pattern per digit.
- Sits between game logic (brick-hit events) and the on-board seven-segment displays.

Parameters:
- DIGITS, 3, number of BCD digits held and displayed (1..8).
- AMT_DIGITS, 2, number of BCD digits in one add amount (1..DIGITS).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  zero the score and abort any add in flight; best is kept.
- add_valid  in  1  add request.
- add_ready  out  1  engine idle; a request is accepted on add_valid && add_ready.
- add_bcd  in  4*AMT_DIGITS  BCD amount to add; any nibble above 9 is clamped to 9.
- add_done  out  1  one-cycle pulse when the new score commits.
- score_bcd  out  4*DIGITS  current score, LSD at bits [3:0].
- best_bcd  out  4*DIGITS  highest committed score since reset.
- saturated  out  1  sticky; set when an add overflowed.
- seg_out  out  7*DIGITS  per-digit segments {g,f,e,d,c,b,a}, active-low; digit 0 at [6:0].

Behaviour:
- Reset values: score_bcd=0, best_bcd=0, saturated=0, add_done=0, add_ready=1. seg_out shows "0" on every digit; with LEADING_ZERO_BLANK_EN, only digit 0 shows "0".
- FSM states: IDLE, ADD.
  - IDLE: add_ready=1.
  - Accept at edge T0: latch the clamped amount, zero-extended to DIGITS digits, into operand. Copy score into work. Digit index=0, carry=0. Go to ADD.
  - ADD: add_ready=0. Each cycle processes one digit, index 0 upward: sum = work[i] + operand[i] + carry; if sum > 9, digit = sum-10 and carry=1, else digit = sum and carry=0.
  - The last digit is processed at edge T0+DIGITS. At that edge: score_bcd <= work, add_done=1 for that cycle, return to IDLE.
- Latency: DIGITS cycles from accept to commit. add_ready is high again in the cycle after commit, so maximum throughput is one add per DIGITS+1 cycles.
- Overflow: if the carry out of the MSD is 1, score_bcd commits as all 9s and saturated<=1. Later adds while saturated still handshake and pulse add_done, but the score stays all 9s.
- Commit is atomic: score_bcd never shows a partially updated value.
- best_bcd: on the edge after a commit, if score_bcd > best_bcd (BCD compare is an unsigned compare of the packed vector), best_bcd <= score_bcd.
- clear:
  - Next edge: score_bcd=0, saturated=0, FSM to IDLE, any in-flight add is discarded (no add_done), add_ready=1 the following cycle.
  - If add_valid is high in the same cycle as clear, the request is not accepted.
  - best_bcd is not affected.
- Priority: reset > clear > add.
- reset mid-ADD: everything returns to reset values, and best_bcd is cleared too.
- seg_out is a combinational decode of score_bcd.
  - Patterns, digits 0-9 (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Blank is 1111111.
- add_bcd is sampled only at acceptance; changes during ADD are ignored.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: any digit i > 0 whose value and all higher digits are zero shows blank (1111111). Digit 0 always displays. Example: score 007 shows "  7".
- Undefined: every digit is decoded as-is. Example: score 007 shows "007".

Decomposition:
- Shared package bcd_score_pkg holds:
  - the FSM state enum;
  - SEG_BLANK;
  - the 10-entry segment-pattern constant table;
  - a BCD-digit-add function returning {carry, digit}.
- One sub-module, bcd_seg_decoder: 4-bit digit plus a blank input, giving a 7-bit active-low pattern. It is instantiated DIGITS times in a generate loop.

Test Plan:
- Reset, then add_bcd=8'h07 -> add_ready falls; after 3 cycles score_bcd=12'h007, add_done pulses once, seg_out[6:0]=1111000.
- Score 12'h095 plus add 8'h07 -> score 12'h102 (carry ripples through two digits); best_bcd=12'h102 one cycle later.
- Score 12'h995 plus add 8'h10 -> score 12'h999, saturated=1; a further add of 8'h01 -> still 12'h999, add_done pulses.
- clear asserted one cycle after accepting 8'h05 from 12'h200 -> no add_done, score 12'h000, best unchanged at its prior value, add_ready=1 next cycle.
- add_bcd=8'h0F (nibble clamped to 9) from 0 -> score 12'h009. add_valid held high back-to-back -> accepts spaced exactly DIGITS+1 cycles apart.
- reset asserted mid-ADD -> all outputs at reset values on the next edge, best_bcd=0. With LEADING_ZERO_BLANK_EN, score 12'h000 shows digit 2 and digit 1 blank.
